// File: rtl/addsub_seq_pkg.sv
// ============================================================================
// addsub_seq_pkg : shared state encoding, slice width and overflow helper
// Rev 1.0
// ============================================================================
`default_nettype none

package addsub_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic signed_ovfl(input logic a_msb, input logic b_msb, input logic r_msb);
    return (~a_msb & ~b_msb & r_msb) | (a_msb & b_msb & ~r_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice4.sv
// ============================================================================
// addsub_slice4 : combinational 4-bit ripple add with carry-in / carry-out
// Rev 1.0
// ============================================================================
`default_nettype none

module addsub_slice4
  import addsub_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[SLICE_W-1:0];
  assign o_cout = w_full[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/addsub_seq.sv
// ============================================================================
// addsub_seq : sequential signed add/subtract, one 4-bit slice per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NSL    = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int SH     = $clog2(SLICE_W);
  localparam int BASE_W = IDX_W + SH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_bop;
  logic [WIDTH-1:0]   r_raw;
  logic               r_sat;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovfl;
  logic               r_zero;
  logic               r_neg;

  logic [BASE_W-1:0]  w_base;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_ovfl;
  logic [WIDTH-1:0]   w_sat_val;
  logic [WIDTH-1:0]   w_final;

  // Bit offset of the slice currently being processed.
  assign w_base = BASE_W'(r_idx) << SH;
  assign w_a_sl = r_a[w_base +: SLICE_W];
  assign w_b_sl = r_bop[w_base +: SLICE_W];

  addsub_slice4 u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ovfl    = signed_ovfl(r_a[WIDTH-1], r_bop[WIDTH-1], r_raw[WIDTH-1]);
  assign w_sat_val = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_final   = (r_sat && w_ovfl) ? w_sat_val : r_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        // The first DONE cycle latches the final result; handshake only after that.
        if (r_out_valid && out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_bop       <= '0;
      r_raw       <= '0;
      r_sat       <= SAT_DEFAULT;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovfl      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            r_a     <= a;
            r_bop   <= sub ? ~b : b;
            r_carry <= sub;
            r_sat   <= sat;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_raw[w_base +: SLICE_W] <= w_sum;
          r_carry                  <= w_cout;
          r_idx                    <= r_idx + IDX_W'(1);
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= w_final;
            r_ovfl      <= w_ovfl;
            r_zero      <= (w_final == '0);
            r_neg       <= w_final[WIDTH-1];
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovfl      = r_ovfl;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq.sv
// ============================================================================
// tb_addsub_seq : directed self-checking bench for addsub_seq (WIDTH=16)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovfl;
  logic        zero;
  logic        neg;

  int n_checks;
  int n_pass;

  addsub_seq #(.WIDTH(16), .SAT_DEFAULT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovfl      (ovfl),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] r;
    logic        o;
    logic        z;
    logic        n;
  } vec_t;

  // Accepts one request and returns cycles from the accept edge to out_valid.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                       input logic tsat, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; a = ta; b = tb; sub = tsub; sat = tsat;
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~tsub; sat = ~tsat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else n_pass++;
    n_checks++; if ({ovfl, zero, neg} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ovfl, zero, neg}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_arith();
    vec_t vecs[9];
    int   lat;
    vecs[0] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, lat);
      n_checks++; if (lat !== 5) $display("FAIL arith%0d_latency got %0d want 5", i, lat); else n_pass++;
      n_checks++; if (result !== vecs[i].r) $display("FAIL arith%0d_result got %h want %h", i, result, vecs[i].r); else n_pass++;
      n_checks++; if (ovfl !== vecs[i].o) $display("FAIL arith%0d_ovfl got %b want %b", i, ovfl, vecs[i].o); else n_pass++;
      n_checks++; if (zero !== vecs[i].z) $display("FAIL arith%0d_zero got %b want %b", i, zero, vecs[i].z); else n_pass++;
      n_checks++; if (neg !== vecs[i].n) $display("FAIL arith%0d_neg got %b want %b", i, neg, vecs[i].n); else n_pass++;
      out_ready = 1'b1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL arith%0d_no_bypass got %b want 0", i, in_ready); else n_pass++;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL arith%0d_release got v/r %b want 01", i, {out_valid, in_ready}); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int lat;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 5) $display("FAIL stall_latency got %0d want 5", lat); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b1; sat = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, result} !== {2'b10, 16'h3333})
        $display("FAIL stall_hold%0d got v/r/res %b/%b/%h want 1/0/3333", i, out_valid, in_ready, result);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_no_accept got v/r %b want 01", {out_valid, in_ready}); else n_pass++;
  endtask

  task automatic test_reset_midcalc();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; sub = 1'b0; sat = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, result} !== {2'b10, 16'h0000})
      $display("FAIL midreset_state got r/v/res %b/%b/%h want 1/0/0000", in_ready, out_valid, result);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_discard got %b want 0", out_valid); else n_pass++;
    issue(16'h0003, 16'h0007, 1'b1, 1'b0, lat);
    n_checks++; if (lat !== 5) $display("FAIL midreset_latency got %0d want 5", lat); else n_pass++;
    n_checks++;
    if ({result, ovfl, zero, neg} !== {16'hFFFC, 3'b001})
      $display("FAIL midreset_result got %h/%b want fffc/001", result, {ovfl, zero, neg});
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    issue(16'h0010, 16'h0020, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 5) $display("FAIL b2b0_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (result !== 16'h0030) $display("FAIL b2b0_result got %h want 0030", result); else n_pass++;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL b2b0_one_cycle got v/r %b want 01", {out_valid, in_ready}); else n_pass++;
    issue(16'h7000, 16'h1000, 1'b0, 1'b1, lat);
    n_checks++; if (lat !== 5) $display("FAIL b2b1_latency got %0d want 5", lat); else n_pass++;
    n_checks++;
    if ({result, ovfl, zero, neg} !== {16'h7FFF, 3'b100})
      $display("FAIL b2b1_result got %h/%b want 7fff/100", result, {ovfl, zero, neg});
    else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b1_one_cycle got %b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_arith();
    test_stall();
    test_reset_midcalc();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
